// File: rtl/aes_uart_ctrl_pkg.sv
// Shared types and constants for the UART/AES command sequencer.
// Command, response bytes and the sequencer state encoding.
package aes_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    KEY,
    RUN,
    WAIT_AES,
    SEND,
    TX_WAIT
  } state_e;

  localparam int DEF_BLOCK_BYTES = 16;
  localparam int DEF_TIMEOUT     = 50000;

  localparam logic [7:0] CMD_KEY = 8'h4B;
  localparam logic [7:0] CMD_ENC = 8'h45;
  localparam logic [7:0] ACK     = 8'h06;
  localparam logic [7:0] NAK     = 8'h15;

  function automatic logic is_cmd(input logic [7:0] b);
    return (b == CMD_KEY) || (b == CMD_ENC);
  endfunction

endpackage

// File: rtl/aes_uart_ctrl_shifter.sv
// Byte-wide shift register: collects payload MSB-first and
// streams responses MSB-first, tracking how many bytes it holds.
module byte_shifter128
  import aes_uart_pkg::*;
#(
  parameter int BYTES = DEF_BLOCK_BYTES,
  localparam int W  = 8 * BYTES,
  localparam int CW = $clog2(BYTES + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          load_i,
  input  logic [W-1:0]  load_data_i,
  input  logic [CW-1:0] load_cnt_i,
  input  logic          shin_i,
  input  logic [7:0]    byte_i,
  input  logic          shout_i,
  output logic [W-1:0]  data_o,
  output logic [7:0]    byte_o,
  output logic [CW-1:0] cnt_o
);

  logic [W-1:0]  data_q;
  logic [CW-1:0] cnt_q;

  // Clear beats load beats shift-in beats shift-out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else if (clr_i) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else if (load_i) begin
      data_q <= load_data_i;
      cnt_q  <= load_cnt_i;
    end else if (shin_i) begin
      data_q <= {data_q[W-9:0], byte_i};
      cnt_q  <= cnt_q + CW'(1);
    end else if (shout_i) begin
      data_q <= {data_q[W-9:0], 8'h00};
      cnt_q  <= cnt_q - CW'(1);
    end
  end

  assign data_o = data_q;
  assign byte_o = data_q[W-1:W-8];
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/aes_uart_ctrl.sv
// Command sequencer between the UART byte stream and an AES-128 core:
// parses key/encrypt frames, drives the core, streams the reply.
module aes_uart_ctrl
  import aes_uart_pkg::*;
#(
  parameter int BLOCK_BYTES    = DEF_BLOCK_BYTES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rx_valid,
  input  logic [7:0]   rx_data,
  input  logic         tx_busy,
  output logic         tx_start,
  output logic [7:0]   tx_data,
  output logic         key_load,
  output logic [127:0] key_out,
  output logic         aes_start,
  output logic [127:0] aes_in,
  input  logic         aes_done,
  input  logic [127:0] aes_out,
  output logic         busy,
  output logic         err
);

  localparam int W  = 8 * BLOCK_BYTES;
  localparam int CW = $clog2(BLOCK_BYTES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST   = CW'(BLOCK_BYTES - 1);
  localparam logic [CW-1:0] FULL_N = CW'(BLOCK_BYTES);
  localparam logic [CW-1:0] ONE    = CW'(1);

  state_e        state_q, state_d;
  logic          cmd_key_q, cmd_key_d;
  logic          err_q, err_d;
  logic          wait_q, wait_d;
  logic [TW-1:0] to_q, to_d;
  logic [W-1:0]  key_q, key_d;
  logic [W-1:0]  ain_q, ain_d;

  logic          sh_clr, sh_load, sh_in, sh_out;
  logic [W-1:0]  sh_ld_data, sh_data, full;
  logic [CW-1:0] sh_ld_cnt, sh_cnt;
  logic [7:0]    sh_byte;

  byte_shifter128 #(.BYTES(BLOCK_BYTES)) u_shift (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (sh_clr),
    .load_i      (sh_load),
    .load_data_i (sh_ld_data),
    .load_cnt_i  (sh_ld_cnt),
    .shin_i      (sh_in),
    .byte_i      (rx_data),
    .shout_i     (sh_out),
    .data_o      (sh_data),
    .byte_o      (sh_byte),
    .cnt_o       (sh_cnt)
  );

  // Block as it will look once the byte on rx_data is shifted in,
  // so key_out/aes_in are already valid during key_load/aes_start.
  assign full = {sh_data[W-9:0], rx_data};

  // Next-state, datapath updates and one-cycle strobes.
  always_comb begin
    state_d    = state_q;
    cmd_key_d  = cmd_key_q;
    err_d      = err_q;
    wait_d     = 1'b0;
    to_d       = '0;
    key_d      = key_q;
    ain_d      = ain_q;
    sh_clr     = 1'b0;
    sh_load    = 1'b0;
    sh_ld_data = '0;
    sh_ld_cnt  = '0;
    sh_in      = 1'b0;
    sh_out     = 1'b0;
    tx_start   = 1'b0;
    key_load   = 1'b0;
    aes_start  = 1'b0;

    if (rx_valid && !(state_q inside {IDLE, LOAD}))
      err_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (rx_valid) begin
          if (is_cmd(rx_data)) begin
            cmd_key_d = (rx_data == CMD_KEY);
            err_d     = 1'b0;
            sh_clr    = 1'b1;
            state_d   = LOAD;
          end else begin
            err_d      = 1'b1;
            sh_load    = 1'b1;
            sh_ld_data = {NAK, {(W-8){1'b0}}};
            sh_ld_cnt  = ONE;
            state_d    = SEND;
          end
        end
      end
      LOAD: begin
        if (rx_valid) begin
          sh_in = 1'b1;
          if (sh_cnt == LAST) begin
            if (cmd_key_q) begin
              key_d   = full;
              state_d = KEY;
            end else begin
              ain_d   = full;
              state_d = RUN;
            end
          end
        end else if (to_q == TO_MAX) begin
          err_d      = 1'b1;
          sh_load    = 1'b1;
          sh_ld_data = {NAK, {(W-8){1'b0}}};
          sh_ld_cnt  = ONE;
          state_d    = SEND;
        end else begin
          to_d = to_q + TW'(1);
        end
      end
      KEY: begin
        key_load   = 1'b1;
        sh_load    = 1'b1;
        sh_ld_data = {ACK, {(W-8){1'b0}}};
        sh_ld_cnt  = ONE;
        state_d    = SEND;
      end
      RUN: begin
        aes_start = 1'b1;
        state_d   = WAIT_AES;
      end
      WAIT_AES: begin
        if (aes_done) begin
          sh_load    = 1'b1;
          sh_ld_data = aes_out;
          sh_ld_cnt  = FULL_N;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          sh_out   = 1'b1;
          state_d  = TX_WAIT;
        end
      end
      TX_WAIT: begin
        if (!wait_q || tx_busy)
          wait_d = 1'b1;
        else
          state_d = (sh_cnt != '0) ? SEND : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cmd_key_q <= 1'b0;
      err_q     <= 1'b0;
      wait_q    <= 1'b0;
      to_q      <= '0;
      key_q     <= '0;
      ain_q     <= '0;
    end else begin
      state_q   <= state_d;
      cmd_key_q <= cmd_key_d;
      err_q     <= err_d;
      wait_q    <= wait_d;
      to_q      <= to_d;
      key_q     <= key_d;
      ain_q     <= ain_d;
    end
  end

  assign tx_data = tx_start ? sh_byte : 8'h00;
  assign key_out = key_q;
  assign aes_in  = ain_q;
  assign err     = err_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_aes_uart_ctrl.sv
// Self-checking bench for aes_uart_ctrl with UART and AES
// stand-ins and a frame-level reference model.
module tb_aes_uart_ctrl;

  localparam int TO = 300;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] ACK_V    = {8'h06, 120'h0};
  localparam logic [127:0] NAK_V    = {8'h15, 120'h0};

  logic         clk = 1'b0;
  logic         rst;
  logic         rx_valid;
  logic [7:0]   rx_data;
  logic         tx_busy;
  logic         tx_start;
  logic [7:0]   tx_data;
  logic         key_load;
  logic [127:0] key_out;
  logic         aes_start;
  logic [127:0] aes_in;
  logic         aes_done;
  logic [127:0] aes_out;
  logic         busy;
  logic         err;

  int checks = 0;
  int failures = 0;
  logic [7:0] txq[$];
  int n_kl = 0;
  int n_as = 0;
  logic [127:0] kl_val = '0;
  logic [127:0] as_val = '0;
  int aes_lat = 0;

  always #5 clk = ~clk;

  aes_uart_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .tx_busy   (tx_busy),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .key_load  (key_load),
    .key_out   (key_out),
    .aes_start (aes_start),
    .aes_in    (aes_in),
    .aes_done  (aes_done),
    .aes_out   (aes_out),
    .busy      (busy),
    .err       (err)
  );

  function automatic logic [127:0] fake_aes(input logic [127:0] pt,
                                            input logic [127:0] k);
    if (pt == FIPS_PT && k == FIPS_KEY) return FIPS_CT;
    return pt ^ {k[63:0], k[127:64]} ^
           128'hA5A5_A5A5_3C3C_3C3C_5A5A_5A5A_C3C3_C3C3;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // UART transmitter stand-in: busy from the cycle after tx_start.
  initial begin
    int left;
    bit arm;
    logic s;
    logic [7:0] d;
    left = 0;
    arm = 1'b0;
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      s = tx_start;
      d = tx_data;
      if (left > 0) begin
        left--;
        if (left == 0) tx_busy = 1'b0;
      end
      if (arm) begin
        tx_busy = 1'b1;
        left = $urandom_range(1, 6);
        arm = 1'b0;
      end
      if (s) begin
        txq.push_back(d);
        arm = 1'b1;
      end
    end
  end

  // AES core stand-in plus strobe monitor.
  initial begin
    int cnt;
    logic [127:0] res;
    cnt = 0;
    res = '0;
    aes_done = 1'b0;
    aes_out = '0;
    forever begin
      @(negedge clk);
      aes_done = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          aes_done = 1'b1;
          aes_out = res;
        end
      end
      if (aes_start) begin
        n_as++;
        as_val = aes_in;
        res = fake_aes(aes_in, key_out);
        cnt = (aes_lat > 0) ? aes_lat : $urandom_range(1, 8);
      end
      if (key_load) begin
        n_kl++;
        kl_val = key_out;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data = 8'h00;
  endtask

  // gap < 0: random 0..3 idle cycles before each payload byte.
  task automatic send_frame(input logic [7:0] cmd, input logic [127:0] p,
                            input int gap);
    send_byte(cmd);
    for (int i = 0; i < 16; i++) begin
      repeat ((gap < 0) ? $urandom_range(0, 3) : gap) @(negedge clk);
      send_byte(p[127-8*i -: 8]);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_idle"}, 128'(busy), 128'(0));
  endtask

  task automatic check_tx(input string tag, input logic [127:0] exp,
                          input int nb);
    chk({tag, "_txlen"}, 128'(txq.size()), 128'(nb));
    for (int i = 0; i < nb && i < txq.size(); i++)
      chk($sformatf("%s_tx%0d", tag, i), 128'(txq[i]),
          128'(exp[127-8*i -: 8]));
    txq.delete();
  endtask

  task automatic enc_frame(input string tag, input logic [127:0] p,
                           input logic [127:0] k, input int gap);
    int n0;
    n0 = n_as;
    send_frame(8'h45, p, gap);
    wait_idle(tag);
    chk({tag, "_nstart"}, 128'(n_as), 128'(n0 + 1));
    chk({tag, "_aes_in"}, as_val, p);
    check_tx(tag, fake_aes(p, k), 16);
  endtask

  task automatic key_frame(input string tag, input logic [127:0] k);
    int n0;
    n0 = n_kl;
    send_frame(8'h4B, k, -1);
    wait_idle(tag);
    chk({tag, "_nload"}, 128'(n_kl), 128'(n0 + 1));
    chk({tag, "_kl_val"}, kl_val, k);
    chk({tag, "_key_out"}, key_out, k);
    chk({tag, "_err"}, 128'(err), 128'(0));
    check_tx(tag, ACK_V, 1);
  endtask

  initial begin
    logic [127:0] mkey;
    logic [127:0] p;
    int n0;
    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    mkey = '0;
    repeat (3) @(negedge clk);
    chk("rst_ctl", 128'({tx_start, tx_data, key_load, aes_start, busy, err}),
        128'(0));
    chk("rst_key", key_out, 128'(0));
    chk("rst_ain", aes_in, 128'(0));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    key_frame("fips_key", FIPS_KEY);
    mkey = FIPS_KEY;
    enc_frame("fips_enc", FIPS_PT, mkey, -1);
    chk("fips_err", 128'(err), 128'(0));

    send_byte(8'h98);
    wait_idle("badcmd");
    chk("badcmd_err", 128'(err), 128'(1));
    check_tx("badcmd", NAK_V, 1);
    p = {$urandom, $urandom, $urandom, $urandom};
    key_frame("after_bad", p);
    mkey = p;

    n0 = n_as;
    send_byte(8'h45);
    for (int i = 0; i < 5; i++) send_byte(8'($urandom));
    wait_idle("timeout");
    chk("timeout_err", 128'(err), 128'(1));
    check_tx("timeout", NAK_V, 1);
    chk("timeout_nostart", 128'(n_as), 128'(n0));
    chk("timeout_key", key_out, mkey);

    p = {$urandom, $urandom, $urandom, $urandom};
    enc_frame("longgap", p, mkey, TO - 1);
    chk("longgap_err", 128'(err), 128'(0));

    aes_lat = 6;
    n0 = n_as;
    p = {$urandom, $urandom, $urandom, $urandom};
    send_frame(8'h45, p, -1);
    chk("ovr_start_now", 128'(aes_start), 128'(1));
    @(negedge clk);
    send_byte(8'h00);
    wait_idle("ovr");
    chk("ovr_err", 128'(err), 128'(1));
    chk("ovr_nstart", 128'(n_as), 128'(n0 + 1));
    check_tx("ovr", fake_aes(p, mkey), 16);
    aes_lat = 0;

    send_byte(8'h45);
    for (int i = 0; i < 8; i++) send_byte(8'($urandom));
    rst = 1'b1;
    #1;
    chk("midrst_ctl",
        128'({tx_start, tx_data, key_load, aes_start, busy, err}), 128'(0));
    chk("midrst_key", key_out, 128'(0));
    chk("midrst_ain", aes_in, 128'(0));
    @(negedge clk);
    rst = 1'b0;
    mkey = '0;
    @(negedge clk);
    p = {$urandom, $urandom, $urandom, $urandom};
    enc_frame("postrst", p, mkey, -1);

    for (int r = 0; r < 6; r++) begin
      p = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 1) == 0) begin
        key_frame($sformatf("rk%0d", r), p);
        mkey = p;
      end else begin
        enc_frame($sformatf("re%0d", r), p, mkey, -1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_uart_ctrl.md
Name: aes_uart_ctrl

Overview:
- Command sequencer between the RS-232 byte receiver/transmitter and the AES-128 core.
- Parses a framed byte stream from the UART: a command byte followed by 16 payload bytes.
- Loads the key or launches an encryption, then streams the response back through the UART transmitter.
- Sits at top level in place of direct RX→port wiring; owns all UART/AES handshakes.

Parameters:
- BLOCK_BYTES, 16, payload bytes per frame (fixed for AES-128; 128 = 8*BLOCK_BYTES).
- TIMEOUT_CYCLES, 50000, max clk cycles between payload bytes before abort (~1 ms at 50 MHz).
- CMD_KEY, 8'h4B, command byte "load key".
- CMD_ENC, 8'h45, command byte "encrypt block".

Ports:
- clk  in  1  system clock (50 MHz).
- rst  in  1  asynchronous reset, active-high.
- rx_valid  in  1  one-cycle strobe: rx_data holds a received byte.
- rx_data  in  8  received byte.
- tx_busy  in  1  transmitter busy; high from cycle after accepted tx_start until stop bit sent.
- tx_start  out  1  one-cycle request to send tx_data.
- tx_data  out  8  byte to send; stable while tx_start=1.
- key_load  out  1  one-cycle pulse: key_out valid, AES core latches key.
- key_out  out  128  key register.
- aes_start  out  1  one-cycle pulse: aes_in valid.
- aes_in  out  128  plaintext register.
- aes_done  in  1  one-cycle pulse: aes_out valid.
- aes_out  in  128  ciphertext.
- busy  out  1  high in every state except IDLE.
- err  out  1  sticky error flag; cleared on next accepted valid command byte.

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0, including key_out, aes_in, err; byte counter 0; timeout counter 0.
- Byte order: first payload byte → bits [127:120]; last → [7:0]. Response bytes are sent in the same MSB-first order.
- IDLE: on rx_valid:
  - CMD_KEY or CMD_ENC → record command, clear err, counter=0 → LOAD.
  - Any other byte → err=1, tx byte 8'h15 (NAK) → SEND.
- LOAD: each rx_valid shifts the byte into the shift register, counter+1, timeout counter reset.
  - When counter reaches BLOCK_BYTES, on the same cycle as the 16th byte: go to KEY (CMD_KEY) or RUN (CMD_ENC).
  - Timeout counter increments each cycle with no rx_valid. At TIMEOUT_CYCLES: err=1, discard payload, NAK → SEND.
- KEY: key_out <= shift register, key_load=1 for exactly one cycle; response ACK byte 8'h06 → SEND.
- RUN: aes_in <= shift register, aes_start=1 for one cycle → WAIT_AES.
- WAIT_AES: on aes_done, latch aes_out into the result register → SEND with 16 response bytes.
- SEND: when tx_busy=0, drive tx_start=1 for one cycle with the current byte → TX_WAIT.
- TX_WAIT: wait one cycle, then wait for tx_busy=0.
  - If bytes remain → SEND.
  - Otherwise → IDLE.
  - Latency from 16th payload byte to first tx_start for ENC: 2 cycles + AES latency + 1.
- rx_valid outside IDLE/LOAD (KEY, RUN, WAIT_AES, SEND, TX_WAIT): byte dropped, err=1; sequence continues.
- rx_valid and timeout expiry on the same cycle: the byte wins (counted, timeout cleared).
- key_out is retained across ENC frames and error aborts; changed only by a completed CMD_KEY frame.
- rst asserted mid-frame or mid-transmission: immediate return to reset values; a partially sent byte is the transmitter's concern.
- Widths: byte counter $clog2(BLOCK_BYTES+1) bits; timeout counter $clog2(TIMEOUT_CYCLES+1) bits, saturating.

Decomposition:
- Shared package aes_uart_pkg:
  - state enum (IDLE, LOAD, KEY, RUN, WAIT_AES, SEND, TX_WAIT).
  - CMD_KEY, CMD_ENC, ACK=8'h06, NAK=8'h15.
- One natural sub-module: byte_shifter128 — a 128-bit shift-in/shift-out register with load, shift-in byte, shift-out byte, and count. Used for both payload collection and response streaming.

Test Plan:
- Key then encrypt (FIPS-197): send 4B, 00 01 … 0F.
  - → key_load pulse with key_out=000102030405060708090a0b0c0d0e0f; TX 06.
- Encrypt after the key above: send 45, 00 11 22 … FF.
  - → aes_start with aes_in=00112233445566778899aabbccddeeff.
  - With a real core: TX 69 c4 e0 d8 6a 7b 04 30 d8 cd b7 80 70 b4 c5 5a.
- Bad command: send 98 → err=1, TX 15, state IDLE. Then send 4B + 16 bytes → err cleared, TX 06.
- Timeout: send 45 + 5 bytes, then idle TIMEOUT_CYCLES → err=1, TX 15, no aes_start; key_out unchanged.
- Overrun: inject rx_valid (byte 00) during WAIT_AES → err=1; all 16 ciphertext bytes still sent.
- Reset mid-LOAD after 8 bytes → all outputs 0, busy=0. A full ENC frame afterwards produces aes_in from the new bytes only.
